// File: rtl/pid_pkg.sv
// Shared types and constants for the PID sequencer: state encoding, default width, saturating helpers.
package pid_pkg;

   localparam int PID_W = 19;

   localparam logic signed [PID_W-1:0] PID_MAX = {1'b0, {(PID_W-1){1'b1}}};
   localparam logic signed [PID_W-1:0] PID_MIN = {1'b1, {(PID_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ERR   = 3'd1,
      MUL_P = 3'd2,
      MUL_I = 3'd3,
      MUL_D = 3'd4,
      SUM   = 3'd5
   } pid_state_e;

   function automatic logic signed [PID_W-1:0] sat_clamp(input logic signed [PID_W:0] v);
      if (v[PID_W] != v[PID_W-1])
         return v[PID_W] ? PID_MIN : PID_MAX;
      return v[PID_W-1:0];
   endfunction

   function automatic logic signed [PID_W-1:0] sat_add(input logic signed [PID_W-1:0] a,
                                                       input logic signed [PID_W-1:0] b);
      return sat_clamp({a[PID_W-1], a} + {b[PID_W-1], b});
   endfunction

   function automatic logic signed [PID_W-1:0] sat_sub(input logic signed [PID_W-1:0] a,
                                                       input logic signed [PID_W-1:0] b);
      return sat_clamp({a[PID_W-1], a} - {b[PID_W-1], b});
   endfunction

endpackage

// File: rtl/pid_sat_add.sv
// Saturating two's-complement add/subtract: computed one bit wider, then clamped to the W-bit range.
module pid_sat_add
   import pid_pkg::*;
#(
   parameter int W   = PID_W,
   parameter bit SUB = 1'b0
) (
   input  logic signed [W-1:0] i_a,
   input  logic signed [W-1:0] i_b,
   output logic signed [W-1:0] o_s
);

   logic signed [W:0] w_full;

   always_comb begin
      if (SUB)
         w_full = {i_a[W-1], i_a} - {i_b[W-1], i_b};
      else
         w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};

      // Sign bits disagree only when the true result left the W-bit range.
      if (w_full[W] != w_full[W-1])
         o_s = w_full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
         o_s = w_full[W-1:0];
   end

endmodule

// File: rtl/pid_sequencer.sv
// PID sample engine sharing one external multiplier; D term present only when PID_DERIV_EN is defined.
//  state | meaning
//  IDLE  | wait for sample_req, capture ref/y/gains
//  ERR   | e = ref - y, de = e - e_prev
//  MUL_P | p_reg = e * Kp
//  MUL_I | integ += e * Ki
//  MUL_D | d_reg = de * Kd (PID_DERIV_EN only)
//  SUM   | u = p_reg + integ + d_reg
module pid_sequencer
   import pid_pkg::*;
#(
   parameter int W = PID_W
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                sample_req,
   input  logic signed [W-1:0] ref_in,
   input  logic signed [W-1:0] y,
   input  logic signed [W-1:0] Kp,
   input  logic signed [W-1:0] Ki,
   input  logic signed [W-1:0] Kd,
   input  logic                int_clr,
   output logic signed [W-1:0] mul_a,
   output logic signed [W-1:0] mul_b,
   input  logic signed [W-1:0] mul_p,
   output logic signed [W-1:0] u,
   output logic                u_valid,
   output logic                busy,
   output logic                overrun
);

   pid_state_e r_state, w_next;

   logic signed [W-1:0] r_ref, r_y, r_kp, r_ki, r_e, r_p, r_integ, r_u;
   logic                r_u_valid, r_overrun;
   logic signed [W-1:0] w_e, w_integ_nxt, w_pi, w_sum, w_d;

`ifdef PID_DERIV_EN
   logic signed [W-1:0] r_kd, r_de, r_d, w_de;

   pid_sat_add #(.W(W), .SUB(1'b1)) u_de (.i_a(w_e), .i_b(r_e), .o_s(w_de));
   assign w_d = r_d;
`else
   logic w_unused_kd;
   assign w_unused_kd = ^Kd;
   assign w_d         = '0;
`endif

   pid_sat_add #(.W(W), .SUB(1'b1)) u_err   (.i_a(r_ref),   .i_b(r_y),     .o_s(w_e));
   pid_sat_add #(.W(W), .SUB(1'b0)) u_integ (.i_a(r_integ), .i_b(mul_p),   .o_s(w_integ_nxt));
   pid_sat_add #(.W(W), .SUB(1'b0)) u_sum_pi(.i_a(r_p),     .i_b(r_integ), .o_s(w_pi));
   pid_sat_add #(.W(W), .SUB(1'b0)) u_sum   (.i_a(w_pi),    .i_b(w_d),     .o_s(w_sum));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      mul_a  = '0;
      mul_b  = '0;
      case (r_state)
         IDLE:  if (sample_req) w_next = ERR;
         ERR:   w_next = MUL_P;
         MUL_P: begin
            mul_a  = r_e;
            mul_b  = r_kp;
            w_next = MUL_I;
         end
         MUL_I: begin
            mul_a  = r_e;
            mul_b  = r_ki;
`ifdef PID_DERIV_EN
            w_next = MUL_D;
`else
            w_next = SUM;
`endif
         end
         MUL_D: begin
`ifdef PID_DERIV_EN
            mul_a  = r_de;
            mul_b  = r_kd;
`endif
            w_next = SUM;
         end
         SUM:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // r_e doubles as e_prev: it is only overwritten in ERR, after de has used the old value.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_ref     <= '0;
         r_y       <= '0;
         r_kp      <= '0;
         r_ki      <= '0;
         r_e       <= '0;
         r_p       <= '0;
         r_integ   <= '0;
         r_u       <= '0;
         r_u_valid <= 1'b0;
         r_overrun <= 1'b0;
`ifdef PID_DERIV_EN
         r_kd      <= '0;
         r_de      <= '0;
         r_d       <= '0;
`endif
      end else begin
         r_u_valid <= (r_state == SUM);
         r_overrun <= sample_req && (r_state != IDLE);
         if (r_state == IDLE && sample_req) begin
            r_ref <= ref_in;
            r_y   <= y;
            r_kp  <= Kp;
            r_ki  <= Ki;
`ifdef PID_DERIV_EN
            r_kd  <= Kd;
`endif
         end
         if (r_state == ERR) begin
            r_e  <= w_e;
`ifdef PID_DERIV_EN
            r_de <= w_de;
`endif
         end
         if (r_state == MUL_P)
            r_p <= mul_p;
`ifdef PID_DERIV_EN
         if (r_state == MUL_D)
            r_d <= mul_p;
`endif
         if (int_clr)
            r_integ <= '0;
         else if (r_state == MUL_I)
            r_integ <= w_integ_nxt;
         if (r_state == SUM)
            r_u <= w_sum;
      end
   end

   assign u       = r_u;
   assign u_valid = r_u_valid;
   assign overrun = r_overrun;
   assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed bench for pid_sequencer with a saturating integer multiplier model; expectations follow PID_DERIV_EN.
module tb_pid_sequencer;

   localparam int W = 19;
`ifdef PID_DERIV_EN
   localparam int LAT = 6;
   localparam int U1  = 36;
`else
   localparam int LAT = 5;
   localparam int U1  = 18;
`endif

   logic                Clk, Reset, sample_req, int_clr;
   logic signed [W-1:0] ref_in, y, Kp, Ki, Kd;
   logic signed [W-1:0] mul_a, mul_b, mul_p, u;
   logic                u_valid, busy, overrun;

   int n_tests = 0;
   int n_fail  = 0;

   pid_sequencer #(.W(W)) dut (
      .Clk(Clk), .Reset(Reset), .sample_req(sample_req),
      .ref_in(ref_in), .y(y), .Kp(Kp), .Ki(Ki), .Kd(Kd), .int_clr(int_clr),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .u(u), .u_valid(u_valid), .busy(busy), .overrun(overrun)
   );

   longint w_a, w_b, w_prod;
   always_comb begin
      w_a    = mul_a;
      w_b    = mul_b;
      w_prod = w_a * w_b;
      if (w_prod > 262143)
         mul_p = 19'h3FFFF;
      else if (w_prod < -262144)
         mul_p = 19'h40000;
      else
         mul_p = w_prod[W-1:0];
   end

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_in(input int r, input int yy, input int kp, input int ki, input int kd);
      ref_in = r[W-1:0];
      y      = yy[W-1:0];
      Kp     = kp[W-1:0];
      Ki     = ki[W-1:0];
      Kd     = kd[W-1:0];
   endtask

   // Issues one sample_req and watches a fixed window; optional second request and int_clr by cycle index.
   task automatic run_sample(input int req2_at, input int clr_at,
                             output int v1, output int v2,
                             output logic signed [W-1:0] u1, output logic signed [W-1:0] u2,
                             output int nbusy, output int novr, output int nval);
      v1 = 0; v2 = 0; u1 = '0; u2 = '0; nbusy = 0; novr = 0; nval = 0;
      @(negedge Clk);
      sample_req = 1'b1;
      for (int n = 1; n <= 2*LAT + 4; n++) begin
         @(posedge Clk);
         #1;
         sample_req = (n == req2_at);
         int_clr    = (n == clr_at);
         if (busy)    nbusy++;
         if (overrun) novr++;
         if (u_valid) begin
            nval++;
            if (nval == 1) begin v1 = n; u1 = u; end
            else           begin v2 = n; u2 = u; end
         end
      end
      int_clr = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge Clk); Reset = 1'b1;
      @(negedge Clk); Reset = 1'b0;
   endtask

   int v1, v2, nbusy, novr, nval, nv_abort;
   logic signed [W-1:0] u1, u2;

   initial begin
      Reset = 1'b1; sample_req = 1'b0; int_clr = 1'b0;
      set_in(0, 0, 0, 0, 0);
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_u", u, 0);
      chk("rst_u_valid", u_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_mul_a", mul_a, 0);
      @(negedge Clk) Reset = 1'b0;

      set_in(10, 4, 2, 1, 3);
      run_sample(0, 0, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t1_u", u1, U1);
      chk("t1_latency", v1, LAT);
      chk("t1_busy_cycles", nbusy, LAT-1);
      chk("t1_nvalid", nval, 1);

      run_sample(0, 0, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t2_u", u1, 24);
      @(negedge Clk) int_clr = 1'b1;
      @(negedge Clk) int_clr = 1'b0;
      run_sample(0, 0, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t2_after_clr_u", u1, 18);

      set_in(262143, -262144, 1, 0, 0);
      run_sample(0, 0, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t3_pos_clamp_u", u1, 262143);

      pulse_reset();
      #1;
      chk("t4_reset_u", u, 0);
      set_in(10, 4, 2, 1, 3);
      run_sample(2, 0, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t4_overrun_pulses", novr, 1);
      chk("t4_nvalid", nval, 1);
      chk("t4_u", u1, U1);

      run_sample(LAT, 0, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t5_nvalid", nval, 2);
      chk("t5_u_first", u1, 24);
      chk("t5_u_second", u2, 30);
      chk("t5_gap", v2 - v1, LAT);
      chk("t5_overrun", novr, 0);

      @(negedge Clk) sample_req = 1'b1;
      @(posedge Clk); #1 sample_req = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1 Reset = 1'b1;
      #1;
      chk("t6_abort_u", u, 0);
      chk("t6_abort_busy", busy, 0);
      chk("t6_abort_mul_a", mul_a, 0);
      @(negedge Clk) Reset = 1'b0;
      nv_abort = 0;
      repeat (8) begin
         @(posedge Clk); #1;
         if (u_valid) nv_abort++;
      end
      chk("t6_abort_nvalid", nv_abort, 0);
      run_sample(0, 0, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t6_u", u1, U1);
      chk("t6_latency", v1, LAT);

      run_sample(0, 3, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t7_clr_in_mul_i_u", u1, 12);
      run_sample(0, 0, v1, v2, u1, u2, nbusy, novr, nval);
      chk("t7_after_u", u1, 18);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
